// File: rtl/eth_pkg.sv
// Shared Ethernet receive constants, rx FSM state type and the reflected CRC-32 dibit step.
// Used by rmii_rx_fcs_check and rmii_byte_delay.
package eth_pkg;

  localparam logic [31:0] CRC32_INIT    = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC32_POLY    = 32'hEDB8_8320;
  localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB_20E3;
  localparam logic [1:0]  PRE_DIBIT     = 2'b01;
  localparam logic [1:0]  SFD_DIBIT     = 2'b11;
  localparam int          FCS_BYTES     = 4;

  typedef enum logic [2:0] {
    DROP = 3'd0,
    IDLE = 3'd1,
    PRE  = 3'd2,
    DATA = 3'd3,
    END  = 3'd4
  } rx_state_e;

  // Two serial steps of the reflected CRC; dibit[0] is the earlier bit on the wire.
  function automatic logic [31:0] crc32_step2(input logic [31:0] crc, input logic [1:0] dibit);
    logic [31:0] c;
    c = crc;
    for (int i = 0; i < 2; i++) begin
      c = (c[0] ^ dibit[i]) ? ((c >> 1) ^ CRC32_POLY) : (c >> 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/rmii_byte_delay.sv
// Fixed-depth byte delay line: each push shifts a byte in and, once full, emits the oldest byte
// one cycle later. Flush empties the line so the trailing FCS bytes are never emitted.
module rmii_byte_delay
  import eth_pkg::*;
#(
  parameter int DEPTH = FCS_BYTES
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  logic       flush,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       out_valid
);

  localparam int FILL_W = $clog2(DEPTH + 1);
  localparam logic [FILL_W-1:0] FULL_C = FILL_W'(DEPTH);

  logic [DEPTH-1:0][7:0] line;
  logic [FILL_W-1:0]     fill;
  logic                  displace;

  assign displace = push && !flush && (fill == FULL_C);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line      <= '0;
      fill      <= '0;
      dout      <= 8'h00;
      out_valid <= 1'b0;
    end else begin
      out_valid <= displace;
      if (displace) begin
        dout <= line[DEPTH-1];
      end
      if (flush) begin
        fill <= '0;
      end else if (push) begin
        line <= {line[DEPTH-2:0], din};
        if (fill != FULL_C) begin
          fill <= fill + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/rmii_rx_fcs_check.sv
// RMII receive front end: preamble/SFD strip, dibit-to-byte assembly, CRC-32 residue check, FCS strip
// and per-frame status. Optional frame counters stat_good/stat_bad when RMII_RX_STATS_EN is defined.
module rmii_rx_fcs_check
  import eth_pkg::*;
#(
  parameter int PREAMBLE_MIN = 8,
  parameter int MIN_FRAME    = 64,
  parameter int LEN_W        = 11
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       rxd,
  input  logic             crs_dv,
  output logic [7:0]       m_data,
  output logic             m_valid,
  output logic             rx_done,
  output logic             rx_ok,
  output logic             rx_crc_err,
  output logic             rx_align_err,
  output logic             rx_runt,
  output logic [LEN_W-1:0] rx_len
`ifdef RMII_RX_STATS_EN
  ,
  output logic [31:0]      stat_good,
  output logic [31:0]      stat_bad
`endif
);

  localparam logic [7:0]  PRE_MIN_C   = 8'(PREAMBLE_MIN);
  localparam logic [15:0] MIN_FRAME_C = 16'(MIN_FRAME);

  // Handshake: m_valid is a one-cycle strobe with no back-pressure; m_data is meaningful only while
  // m_valid=1, and the status bits and rx_len only while rx_done=1.

  rx_state_e        rx_state;
  rx_state_e        rx_state_nxt;
  logic [7:0]       pre_cnt;
  logic [1:0]       dib_idx;
  logic [5:0]       asm_sr;
  logic [31:0]      crc;
  logic [15:0]      byte_cnt;
  logic [LEN_W-1:0] len_cnt;
  logic             pre_seen;
  logic             data_dibit;
  logic             frame_end;
  logic             byte_done;
  logic [7:0]       byte_full;
  logic             crc_bad;
  logic             align_bad;
  logic             runt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state <= DROP;
    end else begin
      rx_state <= rx_state_nxt;
    end
  end

  always_comb begin
    rx_state_nxt = rx_state;
    unique case (rx_state)
      DROP: if (!crs_dv) rx_state_nxt = IDLE;
      IDLE: if (crs_dv && (rxd == PRE_DIBIT)) rx_state_nxt = PRE;
      PRE: begin
        if (!crs_dv) begin
          rx_state_nxt = IDLE;
        end else if (rxd == PRE_DIBIT) begin
          rx_state_nxt = PRE;
        end else if ((rxd == SFD_DIBIT) && (pre_cnt >= PRE_MIN_C)) begin
          rx_state_nxt = DATA;
        end else begin
          rx_state_nxt = DROP;
        end
      end
      DATA: if (!crs_dv) rx_state_nxt = END;
      END:  rx_state_nxt = IDLE;
      default: rx_state_nxt = DROP;
    endcase
  end

  always_comb begin
    pre_seen   = 1'b0;
    data_dibit = 1'b0;
    frame_end  = 1'b0;
    unique case (rx_state)
      IDLE, PRE: pre_seen = crs_dv && (rxd == PRE_DIBIT);
      DATA:      data_dibit = crs_dv;
      END:       frame_end = 1'b1;
      default: ;
    endcase
  end

  // The fourth dibit is still on rxd when the byte completes, so the byte is formed combinationally.
  assign byte_done = data_dibit && (dib_idx == 2'd3);
  assign byte_full = {rxd, asm_sr};
  assign crc_bad   = (crc != CRC32_RESIDUE);
  assign align_bad = (dib_idx != 2'd0);
  assign runt      = (byte_cnt < MIN_FRAME_C);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt  <= 8'd0;
      dib_idx  <= 2'd0;
      asm_sr   <= 6'd0;
      crc      <= CRC32_INIT;
      byte_cnt <= 16'd0;
      len_cnt  <= '0;
    end else begin
      if (rx_state == IDLE) begin
        pre_cnt <= pre_seen ? 8'd1 : 8'd0;
      end else if (pre_seen && (pre_cnt != 8'hFF)) begin
        pre_cnt <= pre_cnt + 8'd1;
      end
      if (data_dibit) begin
        crc     <= crc32_step2(crc, rxd);
        dib_idx <= dib_idx + 2'd1;
        asm_sr  <= {rxd, asm_sr[5:2]};
        if (byte_done && (byte_cnt != 16'hFFFF)) begin
          byte_cnt <= byte_cnt + 16'd1;
        end
      end
      if (m_valid && (len_cnt != {LEN_W{1'b1}})) begin
        len_cnt <= len_cnt + 1'b1;
      end
      if (frame_end) begin
        dib_idx  <= 2'd0;
        asm_sr   <= 6'd0;
        crc      <= CRC32_INIT;
        byte_cnt <= 16'd0;
        len_cnt  <= '0;
      end
    end
  end

  rmii_byte_delay #(
    .DEPTH (FCS_BYTES)
  ) u_byte_delay (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (byte_done),
    .flush     (frame_end),
    .din       (byte_full),
    .dout      (m_data),
    .out_valid (m_valid)
  );

  // Status is registered out of END, which keeps rx_done two cycles behind the last payload byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_done      <= 1'b0;
      rx_ok        <= 1'b0;
      rx_crc_err   <= 1'b0;
      rx_align_err <= 1'b0;
      rx_runt      <= 1'b0;
      rx_len       <= '0;
    end else begin
      rx_done      <= frame_end;
      rx_ok        <= frame_end && !(crc_bad || align_bad || runt);
      rx_crc_err   <= frame_end && crc_bad;
      rx_align_err <= frame_end && align_bad;
      rx_runt      <= frame_end && runt;
      rx_len       <= frame_end ? len_cnt : '0;
    end
  end

`ifdef RMII_RX_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_good <= 32'd0;
      stat_bad  <= 32'd0;
    end else if (rx_done) begin
      if (rx_ok) begin
        stat_good <= stat_good + 32'd1;
      end else begin
        stat_bad <= stat_bad + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_rmii_rx_fcs_check.sv
// Self-checking bench for rmii_rx_fcs_check: directed frames plus randomized frames, scored against
// a frame-level model (bytes, FCS recomputed bytewise, status rules) held in expected queues.
module tb_rmii_rx_fcs_check;

  localparam int          LEN_W     = 11;
  localparam int          MIN_FRAME = 64;
  localparam int          LEN_MAX   = (1 << LEN_W) - 1;
  localparam logic [31:0] POLY      = 32'hEDB8_8320;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [1:0]       rxd = 2'b00;
  logic             crs_dv = 1'b0;
  logic [7:0]       m_data;
  logic             m_valid;
  logic             rx_done;
  logic             rx_ok;
  logic             rx_crc_err;
  logic             rx_align_err;
  logic             rx_runt;
  logic [LEN_W-1:0] rx_len;
`ifdef RMII_RX_STATS_EN
  logic [31:0]      stat_good;
  logic [31:0]      stat_bad;
`endif

  rmii_rx_fcs_check #(
    .PREAMBLE_MIN (8),
    .MIN_FRAME    (MIN_FRAME),
    .LEN_W        (LEN_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rxd          (rxd),
    .crs_dv       (crs_dv),
    .m_data       (m_data),
    .m_valid      (m_valid),
    .rx_done      (rx_done),
    .rx_ok        (rx_ok),
    .rx_crc_err   (rx_crc_err),
    .rx_align_err (rx_align_err),
    .rx_runt      (rx_runt),
    .rx_len       (rx_len)
`ifdef RMII_RX_STATS_EN
    ,
    .stat_good    (stat_good),
    .stat_bad     (stat_bad)
`endif
  );

  // ---------------- clock / reset ----------------
  always #10 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #(20 * 40000);
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  typedef struct {
    logic ok;
    logic crc_err;
    logic align;
    logic runt;
    int   len;
    int   nemit;
  } st_t;

  logic [7:0] exp_q[$];
  st_t        exp_st[$];
  st_t        st_mon;
  int n_checks = 0;
  int n_fail = 0;
  int done_cnt = 0;
  int exp_done = 0;
  int frame_bytes = 0;
  int last_valid_cyc = -100;
  int good_cnt = 0;
  int bad_cnt = 0;

  logic [7:0] pl_q[$];
  logic [1:0] frame_d[$];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (m_valid && rx_done) check_eq("valid_done_overlap", 1'b1, 1'b0);
    if (m_valid) begin
      if (exp_q.size() == 0) check_eq("spurious_m_valid", m_valid, 1'b0);
      else check_eq("m_data", m_data, exp_q.pop_front());
      last_valid_cyc = cyc;
      frame_bytes++;
    end
    if (rx_done) begin
      if (exp_st.size() == 0) begin
        check_eq("spurious_rx_done", rx_done, 1'b0);
      end else begin
        st_mon = exp_st.pop_front();
        check_eq("rx_ok", rx_ok, st_mon.ok);
        check_eq("rx_crc_err", rx_crc_err, st_mon.crc_err);
        check_eq("rx_align_err", rx_align_err, st_mon.align);
        check_eq("rx_runt", rx_runt, st_mon.runt);
        check_eq("rx_len", rx_len, st_mon.len);
        check_eq("byte_count", frame_bytes, st_mon.nemit);
        if (st_mon.nemit > 0) check_eq("done_gap_ge2", (cyc - last_valid_cyc) >= 2, 1'b1);
        if (st_mon.ok) good_cnt++;
        else bad_cnt++;
      end
      frame_bytes = 0;
      done_cnt++;
    end
  end

  // ---------------- reference model ----------------
  function automatic logic [31:0] fcs_of(input logic [7:0] b[$]);
    logic [31:0] c;
    c = 32'hFFFF_FFFF;
    foreach (b[i]) begin
      c ^= {24'h0, b[i]};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ POLY) : (c >> 1);
    end
    return ~c;
  endfunction

  // Frame = payload + FCS (LSB byte first), optional bit flip, optional trailing dibits.
  task automatic build_data(input int flip_byte, input int flip_bit, input int extra, input logic [1:0] extra_val);
    logic [7:0]  fr[$];
    logic [31:0] f;
    fr = pl_q;
    f = fcs_of(pl_q);
    for (int i = 0; i < 4; i++) fr.push_back(f[8*i +: 8]);
    if (flip_byte >= 0) fr[flip_byte][flip_bit] = ~fr[flip_byte][flip_bit];
    frame_d.delete();
    foreach (fr[i]) for (int k = 0; k < 4; k++) frame_d.push_back(fr[i][2*k +: 2]);
    repeat (extra) frame_d.push_back(extra_val);
  endtask

  task automatic expect_frame();
    int nd, nb, nemit;
    logic [7:0]  b[$];
    logic [7:0]  body[$];
    logic [31:0] f;
    logic        good;
    st_t         s;
    nd = frame_d.size();
    nb = nd / 4;
    for (int j = 0; j < nb; j++)
      b.push_back({frame_d[4*j+3], frame_d[4*j+2], frame_d[4*j+1], frame_d[4*j]});
    good = 1'b0;
    if ((nd % 4 == 0) && (nb >= 4)) begin
      for (int j = 0; j < nb - 4; j++) body.push_back(b[j]);
      f = fcs_of(body);
      good = (f == {b[nb-1], b[nb-2], b[nb-3], b[nb-4]});
    end
    nemit = (nb >= 4) ? nb - 4 : 0;
    for (int j = 0; j < nemit; j++) exp_q.push_back(b[j]);
    s.align   = (nd % 4) != 0;
    s.runt    = nb < MIN_FRAME;
    s.crc_err = !good;
    s.ok      = !(s.align || s.runt || s.crc_err);
    s.nemit   = nemit;
    s.len     = (nemit > LEN_MAX) ? LEN_MAX : nemit;
    exp_st.push_back(s);
    exp_done++;
  endtask

  // ---------------- drivers ----------------
  task automatic drive_dibit(input logic [1:0] d);
    @(negedge clk);
    crs_dv = 1'b1;
    rxd = d;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(negedge clk);
      crs_dv = 1'b0;
      rxd = 2'b00;
    end
  endtask

  task automatic drive_frame(input int pre_len, input int gap);
    repeat (pre_len) drive_dibit(2'b01);
    drive_dibit(2'b11);
    foreach (frame_d[i]) drive_dibit(frame_d[i]);
    idle_cycles(gap);
  endtask

  task automatic send_frame(input int flip_byte, input int flip_bit, input int extra,
                            input logic [1:0] extra_val, input int pre_len, input int gap);
    build_data(flip_byte, flip_bit, extra, extra_val);
    expect_frame();
    drive_frame(pre_len, gap);
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while ((done_cnt < exp_done) && (n < 200)) begin
      @(negedge clk);
      n++;
    end
    check_eq(tag, done_cnt, exp_done);
    idle_cycles(4);
    check_eq({tag, "_drained"}, exp_q.size(), 0);
  endtask

  task automatic rand_payload(input int n);
    pl_q.delete();
    repeat (n) pl_q.push_back(8'($urandom_range(0, 255)));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // Reset asserted and released in the middle of traffic.
    crs_dv = 1'b1;
    repeat (3) begin
      @(negedge clk);
      rxd = 2'($urandom_range(0, 3));
    end
    check_eq("rst_m_valid", m_valid, 1'b0);
    check_eq("rst_m_data", m_data, 8'h00);
    check_eq("rst_rx_done", rx_done, 1'b0);
    check_eq("rst_rx_ok", rx_ok, 1'b0);
    check_eq("rst_rx_crc_err", rx_crc_err, 1'b0);
    check_eq("rst_rx_align_err", rx_align_err, 1'b0);
    check_eq("rst_rx_runt", rx_runt, 1'b0);
    check_eq("rst_rx_len", rx_len, 0);
`ifdef RMII_RX_STATS_EN
    check_eq("rst_stat_good", stat_good, 0);
    check_eq("rst_stat_bad", stat_bad, 0);
`endif
    rst_n = 1'b1;
    repeat (200) drive_dibit(2'($urandom_range(0, 3)));
    idle_cycles(3);
    check_eq("midframe_no_done", done_cnt, 0);
    rand_payload(60);
    send_frame(-1, 0, 0, 2'b00, 31, 2);
    wait_done("after_reset_frame");

    // Reference frame, payload 0x00..0x3B.
    pl_q.delete();
    for (int i = 0; i < 60; i++) pl_q.push_back(8'(i));
    send_frame(-1, 0, 0, 2'b00, 31, 2);
    wait_done("good_frame");

    // Same frame, payload byte 10 bit 3 flipped.
    send_frame(10, 3, 0, 2'b00, 31, 2);
    wait_done("crc_err_frame");

    // One trailing dibit.
    send_frame(-1, 0, 1, 2'b00, 31, 2);
    wait_done("align_err_frame");

    // Runt with a valid FCS.
    rand_payload(20);
    send_frame(-1, 0, 0, 2'b00, 31, 2);
    wait_done("runt_frame");

    // Bad dibit at preamble position 5 drops the frame; then two back-to-back good frames.
    rand_payload(60);
    build_data(-1, 0, 0, 2'b00);
    for (int i = 0; i < 5; i++) drive_dibit(2'b01);
    drive_dibit(2'b10);
    for (int i = 0; i < 25; i++) drive_dibit(2'b01);
    drive_dibit(2'b11);
    foreach (frame_d[i]) drive_dibit(frame_d[i]);
    idle_cycles(1);
    check_eq("bad_pre_no_done", done_cnt, exp_done);
    rand_payload(60);
    send_frame(-1, 0, 0, 2'b00, 31, 1);
    rand_payload(60);
    send_frame(-1, 0, 0, 2'b00, 31, 1);
    wait_done("back_to_back");
`ifdef RMII_RX_STATS_EN
    check_eq("stat_good_b2b", stat_good, good_cnt);
    check_eq("stat_bad_b2b", stat_bad, bad_cnt);
`endif

    // Frames shorter than the FCS: empty and two raw bytes.
    frame_d.delete();
    expect_frame();
    drive_frame(31, 3);
    wait_done("empty_frame");
    frame_d.delete();
    repeat (8) frame_d.push_back(2'($urandom_range(0, 3)));
    expect_frame();
    drive_frame(31, 3);
    wait_done("two_byte_frame");

    // Randomized frames.
    for (int n = 0; n < 10; n++) begin
      int len, flip, extra;
      len = $urandom_range(0, 80);
      flip = ($urandom_range(0, 2) == 0) ? $urandom_range(0, len + 3) : -1;
      extra = ($urandom_range(0, 1) == 0) ? $urandom_range(1, 3) : 0;
      rand_payload(len);
      send_frame(flip, $urandom_range(0, 7), extra, 2'($urandom_range(0, 3)),
                 $urandom_range(8, 31), $urandom_range(2, 6));
      wait_done("rand_frame");
    end

    // Length counter saturation, data still forwarded.
    rand_payload(LEN_MAX + 13);
    send_frame(-1, 0, 0, 2'b00, 31, 2);
    wait_done("long_frame");

    // Asynchronous reset in the middle of a frame's data.
    rand_payload(60);
    build_data(-1, 0, 0, 2'b00);
    for (int i = 0; i < 60; i++) exp_q.push_back(pl_q[i]);
    for (int i = 0; i < 31; i++) drive_dibit(2'b01);
    drive_dibit(2'b11);
    for (int i = 0; i < 118; i++) drive_dibit(frame_d[i]);
    #5;
    rst_n = 1'b0;
    #1;
    check_eq("async_rst_m_valid", m_valid, 1'b0);
    check_eq("async_rst_m_data", m_data, 8'h00);
    check_eq("async_rst_rx_done", rx_done, 1'b0);
    check_eq("async_rst_rx_len", rx_len, 0);
    check_eq("pre_reset_bytes_seen", exp_q.size() < 60, 1'b1);
    exp_q.delete();
    frame_bytes = 0;
    good_cnt = 0;
    bad_cnt = 0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 118; i < frame_d.size(); i++) drive_dibit(frame_d[i]);
    idle_cycles(10);
    check_eq("async_rst_no_done", done_cnt, exp_done);
    rand_payload(64);
    send_frame(-1, 0, 0, 2'b00, 31, 2);
    wait_done("after_async_reset");

`ifdef RMII_RX_STATS_EN
    check_eq("stat_good_final", stat_good, good_cnt);
    check_eq("stat_bad_final", stat_bad, bad_cnt);
`endif
    check_eq("status_queue_drained", exp_st.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
